// File: rtl/pipelined_segmented_adder.sv
// Pipelined segmented adder: WIDTH-bit sum computed SEG bits per stage, with the
// carry registered between segments and an optional lower-part-OR approximation
// of the low APPROX_LSB bits, chosen per beat.
//
// Handshake: a beat moves from one side to the other on a rising edge where
// valid and ready are both 1. in_ready is high whenever the whole pipe may
// advance, i.e. the output register is empty or is being drained this cycle;
// out_valid/sum/cout come straight from the last stage and stay stable while
// out_valid=1 and out_ready=0.
//
// WIDTH must be a multiple of SEG.
module pipelined_segmented_adder #(
  parameter int WIDTH      = 16,
  parameter int SEG        = 4,
  parameter int APPROX_LSB = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STAGES = WIDTH / SEG;

  // Pipeline advance: the entire pipe shifts together or holds together.
  logic w_adv;

  // Index 0 is the capture rank; index k+1 holds the result of segment k.
  logic [STAGES:0]   r_vld;
  logic [STAGES:0]   r_cy;
  logic [STAGES-1:0] r_apx;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [1:STAGES];

  logic [WIDTH-1:0]  w_next [1:STAGES];
  logic [STAGES-1:0] w_seg_co;

  assign w_adv     = !r_vld[STAGES] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES];
  assign sum       = r_s[STAGES];
  assign cout      = r_cy[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [SEG:0]     w_c;
    logic [SEG-1:0]   w_s;
    logic [WIDTH-1:0] w_ns;

    // Ripple carry through the SEG cells of this segment; approximate cells
    // OR their inputs and only the top approximate bit produces a carry.
    always_comb begin
      w_c    = '0;
      w_s    = '0;
      w_c[0] = r_cy[k];
      for (int j = 0; j < SEG; j++) begin
        if (r_apx[k] && (k * SEG + j < APPROX_LSB)) begin
          w_s[j]   = r_a[k][k*SEG+j] | r_b[k][k*SEG+j];
          w_c[j+1] = (k * SEG + j == APPROX_LSB - 1) ?
                     (r_a[k][k*SEG+j] & r_b[k][k*SEG+j]) : 1'b0;
        end else begin
          w_s[j]   = r_a[k][k*SEG+j] ^ r_b[k][k*SEG+j] ^ w_c[j];
          w_c[j+1] = (r_a[k][k*SEG+j] & r_b[k][k*SEG+j]) |
                     (w_c[j] & (r_a[k][k*SEG+j] ^ r_b[k][k*SEG+j]));
        end
      end
    end

    if (k == 0) begin : g_first
      assign w_ns = WIDTH'(w_s);
    end else begin : g_rest
      // Merge this segment's bits over the lower segments already computed.
      always_comb begin
        w_ns                = r_s[k];
        w_ns[k*SEG +: SEG]  = w_s;
      end
    end

    assign w_next[k+1] = w_ns;
    assign w_seg_co[k] = w_c[SEG];
  end

  // Pipeline registers: capture the beat, then shift skewed operands, mode,
  // partial sums and carries one rank per advancing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_cy  <= '0;
      r_apx <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      for (int k = 1; k <= STAGES; k++) begin
        r_s[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld    <= {r_vld[STAGES-1:0], in_valid};
      r_a[0]   <= a;
      r_b[0]   <= b;
      r_apx[0] <= approx_en;
      // In approximate mode cin is ignored; the low bits generate the carry.
      r_cy[0]  <= (approx_en && (APPROX_LSB > 0)) ? 1'b0 : cin;
      for (int k = 1; k < STAGES; k++) begin
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_apx[k] <= r_apx[k-1];
      end
      for (int k = 1; k <= STAGES; k++) begin
        r_s[k]  <= w_next[k];
        r_cy[k] <= w_seg_co[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Directed bench for pipelined_segmented_adder (WIDTH=16, SEG=4, APPROX_LSB=4):
// latency, overflow, streaming, stall, approximate mode, mid-flight reset and
// random bubbles/backpressure against an in-order expected queue.
module tb_pipelined_segmented_adder;

  localparam int W = 16;
  localparam int L = 4;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          approx_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;

  pipelined_segmented_adder #(.WIDTH(W), .SEG(4), .APPROX_LSB(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_en(approx_en),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  // Scoreboard state
  logic [W:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_push  = 0;
  int n_pop   = 0;
  int n_flushed = 0;
  logic last_in_ready;

  // Reference: {cout,sum}
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic mx);
    logic [W-L:0] up;
    if (mx) begin
      up = {1'b0, ma[W-1:L]} + {1'b0, mb[W-1:L]} + (W-L+1)'(ma[L-1] & mb[L-1]);
      return {up, ma[L-1:0] | mb[L-1:0]};
    end
    return {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dc, input logic dx);
    in_valid  = v;
    a         = da;
    b         = db;
    cin       = dc;
    approx_en = dx;
  endtask

  // One clock: evaluate handshakes just before the edge, then step past it.
  task automatic cycle();
    #2;
    last_in_ready = in_ready;
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, approx_en));
        n_push++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_out", 32'd1, 32'd0);
        else chk("sb_data", {15'b0, cout, sum}, {15'b0, exp_q.pop_front()});
        n_pop++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  // Approximate/exact interleave table: {a, b, cin, approx} -> {cout, sum}
  logic [W-1:0] t_a   [7] = '{16'h000F, 16'h000F, 16'h0008, 16'h0008, 16'hFFFF, 16'hFFF8, 16'hFFF8};
  logic [W-1:0] t_b   [7] = '{16'h0001, 16'h0001, 16'h0008, 16'h0008, 16'h0000, 16'h0008, 16'h0008};
  logic         t_c   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         t_x   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [W:0]   t_exp [7] = '{17'h0000F, 17'h00011, 17'h00018, 17'h00010,
                              17'h0FFFF, 17'h10008, 17'h10000};

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    int base;
    int ir_bad;
    int seen;

    // Reset
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Latency and wraparound: FFFF + 0001 = 1_0000
    out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    wait_out(n);
    chk("latency", n, 32'd4);
    chk("wrap_sum", {16'b0, sum}, 32'h0000);
    chk("wrap_cout", {31'b0, cout}, 32'd1);
    cycle();

    // Full overflow: FFFF + FFFF + 1 = 1_FFFF
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    wait_out(n);
    chk("ovf_valid", {31'b0, out_valid}, 32'd1);
    chk("ovf_sum", {16'b0, sum}, 32'hFFFF);
    chk("ovf_cout", {31'b0, cout}, 32'd1);
    drain("ovf_drain");

    // 100-beat stream at full rate
    ir_bad = 0;
    base = n_pop;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 1'b0);
      cycle();
      if (!last_in_ready) ir_bad++;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    chk("stream_in_ready", ir_bad, 32'd0);
    chk("stream_rate_empty", exp_q.size(), 32'd0);
    chk("stream_count", n_pop - base, 32'd100);

    // Stall with out_ready=0 while a result is presented
    base = n_pop;
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0); cycle();
    drive(1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b0;
    wait_out(n);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
      cycle();
      chk("stall_in_ready", {31'b0, last_in_ready}, 32'd0);
      chk("stall_sum", {16'b0, sum}, 32'h2345);
      chk("stall_cout", {31'b0, cout}, 32'd0);
    end
    drain("stall_drain");
    chk("stall_count", n_pop - base, 32'd3);

    // Approximate / exact interleave, back-to-back
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, t_a[i], t_b[i], t_c[i], t_x[i]);
      cycle();
      if (out_valid && idx < 7) begin
        chk("apx_tbl", {15'b0, cout, sum}, {15'b0, t_exp[idx]});
        idx++;
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_valid && idx < 7) begin
        chk("apx_tbl", {15'b0, cout, sum}, {15'b0, t_exp[idx]});
        idx++;
      end
    end
    chk("apx_tbl_count", idx, 32'd7);
    drain("apx_drain");

    // Reset with three beats in flight
    drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0); cycle();
    drive(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0); cycle();
    drive(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_flushed = exp_q.size();
    exp_q.delete();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_sum", {16'b0, sum}, 32'd0);
    chk("mid_rst_cout", {31'b0, cout}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    wait_out(n);
    chk("post_rst_latency", n, 32'd4);
    chk("post_rst_sum", {15'b0, cout, sum}, 32'h0303);
    drain("post_rst_drain");

    // Random bubbles and backpressure
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (out_valid) seen++;
    end
    drain("rand_drain");
    chk("rand_activity", {31'b0, seen > 0}, 32'd1);
    chk("total_count", n_pop, n_push - n_flushed);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
